// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner.
// Drives one row low at a time on each prescaler tick and samples the
// synchronized column lines. Presses and releases are debounced over
// DEBOUNCE_SCANS ticks. Each accepted key is reported as code = row*4 + col
// with a one-clk key_valid strobe.
// Optional feature: define KEY_REPEAT_EN to enable auto-repeat of key_valid
// while a key is held. The first repeat comes REPEAT_DELAY ticks after
// acceptance, and later repeats come every REPEAT_RATE ticks.
module keypad_scan #(
  parameter int SCAN_DIV_W     = 13,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 32,
  parameter int REPEAT_RATE    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam logic [3:0]  DS_LIM  = 4'(DEBOUNCE_SCANS);
  localparam logic [15:0] RPT_DLY = 16'(REPEAT_DELAY);
  localparam logic [15:0] RPT_RLD = 16'(REPEAT_DELAY - REPEAT_RATE);

`ifdef KEY_REPEAT_EN
  localparam logic REPEAT_ON = 1'b1;
`else
  localparam logic REPEAT_ON = 1'b0;
`endif

  // Lowest-index low column wins when several columns are pulled low.
  function automatic logic [1:0] first_low(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (!v[0]) begin
      idx = 2'd0;
    end else if (!v[1]) begin
      idx = 2'd1;
    end else if (!v[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  // Row index of the single low bit in a row drive pattern.
  function automatic logic [1:0] row_index(input logic [3:0] r);
    logic [1:0] idx;
    case (r)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Advance to the next row, wrapping from row 3 back to row 0.
  function automatic logic [3:0] rotate_row(input logic [3:0] r);
    return {r[2:0], r[3]};
  endfunction

  logic [3:0]            sync_a_r;
  logic [3:0]            cs_r;
  logic [SCAN_DIV_W-1:0] div_r;
  logic                  tick_s;

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [3:0]  row_r, row_s;
  logic [1:0]  col_r, col_s;
  logic [3:0]  code_r, code_s;
  logic        valid_r, valid_s;
  logic        down_r, down_s;
  logic [15:0] rep_r, rep_s;
  logic        rep_hit_s;

  logic        hit_s;
  logic [1:0]  dec_col_s;

  assign hit_s     = ~(&cs_r);
  assign dec_col_s = first_low(cs_r);
  assign tick_s    = &div_r;

  assign row_out   = row_r;
  assign key_code  = code_r;
  assign key_valid = valid_r;
  assign key_down  = down_r;

  // Two-flop synchronizer for the asynchronous column inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a_r <= 4'b1111;
      cs_r     <= 4'b1111;
    end else begin
      sync_a_r <= col_in;
      cs_r     <= sync_a_r;
    end
  end

  // Free-running prescaler; it wraps naturally after reaching all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + {{(SCAN_DIV_W-1){1'b0}}, 1'b1};
    end
  end

  // State register and registered outputs of the scan FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= SCAN;
      cnt_r   <= 4'd0;
      row_r   <= 4'b1110;
      col_r   <= 2'd0;
      code_r  <= 4'd0;
      valid_r <= 1'b0;
      down_r  <= 1'b0;
      rep_r   <= 16'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      row_r   <= row_s;
      col_r   <= col_s;
      code_r  <= code_s;
      valid_r <= valid_s;
      down_r  <= down_s;
      rep_r   <= rep_s;
    end
  end

  // Next-state logic; every FSM action happens on tick cycles only.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    row_s     = row_r;
    col_s     = col_r;
    code_s    = code_r;
    valid_s   = 1'b0;
    down_s    = down_r;
    rep_s     = rep_r;
    rep_hit_s = 1'b0;
    if (tick_s) begin
      case (state_r)
        SCAN: begin
          if (hit_s) begin
            col_s = dec_col_s;
            if (DS_LIM == 4'd1) begin
              // A single-sample debounce accepts on the capture tick.
              code_s  = {row_index(row_r), dec_col_s};
              valid_s = 1'b1;
              down_s  = 1'b1;
              cnt_s   = 4'd0;
              rep_s   = 16'd0;
              state_s = HELD;
            end else begin
              cnt_s   = 4'd1;
              state_s = DEBOUNCE;
            end
          end else begin
            row_s = rotate_row(row_r);
          end
        end
        DEBOUNCE: begin
          if (hit_s && (dec_col_s == col_r)) begin
            if ((cnt_r + 4'd1) == DS_LIM) begin
              code_s  = {row_index(row_r), col_r};
              valid_s = 1'b1;
              down_s  = 1'b1;
              cnt_s   = 4'd0;
              rep_s   = 16'd0;
              state_s = HELD;
            end else begin
              cnt_s = cnt_r + 4'd1;
            end
          end else begin
            // A bounce or a column change aborts the attempt.
            cnt_s   = 4'd0;
            row_s   = rotate_row(row_r);
            state_s = SCAN;
          end
        end
        HELD: begin
          if (hit_s) begin
            cnt_s = 4'd0;
            if ((rep_r + 16'd1) == RPT_DLY) begin
              rep_hit_s = 1'b1;
              rep_s     = RPT_RLD;
            end else begin
              rep_s = rep_r + 16'd1;
            end
          end else begin
            rep_s = 16'd0;
            if ((cnt_r + 4'd1) == DS_LIM) begin
              // key_code keeps the last accepted key after release.
              down_s  = 1'b0;
              cnt_s   = 4'd0;
              row_s   = rotate_row(row_r);
              state_s = SCAN;
            end else begin
              cnt_s = cnt_r + 4'd1;
            end
          end
        end
        default: begin
          state_s = SCAN;
          cnt_s   = 4'd0;
          row_s   = 4'b1110;
          down_s  = 1'b0;
          rep_s   = 16'd0;
        end
      endcase
    end else begin
      valid_s = 1'b0;
    end
    valid_s = valid_s | (REPEAT_ON & rep_hit_s);
  end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scanner for a 4x4 matrix keypad, the input-side counterpart of the multiplexed 7-segment display driver.
- Drives one keypad row low at a time, at a prescaled rate, and samples the column lines.
- Debounces presses and releases, then reports a 4-bit key code with a one-cycle valid strobe.
- The game's direction/control logic consumes the key code; the code can also be mirrored onto the display's disp_num nibbles.

Parameters:
- SCAN_DIV_W, 13, prescaler width; one scan tick every 2^SCAN_DIV_W clk cycles.
- DEBOUNCE_SCANS, 4, consecutive identical tick samples required to accept a press or a release (range 1..15).
- REPEAT_DELAY, 32, ticks from acceptance to the first auto-repeat (used only with KEY_REPEAT_EN).
- REPEAT_RATE, 8, ticks between subsequent auto-repeats (used only with KEY_REPEAT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- col_in  in  4  keypad columns; active-low, externally pulled up, asynchronous to clk.
- row_out  out  4  keypad rows; active-low, exactly one bit low at all times.
- key_code  out  4  last accepted key; code = row*4 + col.
- key_valid  out  1  one-clk pulse when key_code is newly updated.
- key_down  out  1  high while an accepted key is held.

Behaviour:
- Reset values (async, active-high):
  - row_out=4'b1110, key_code=0, key_valid=0, key_down=0.
  - Prescaler=0, state=SCAN, debounce count=0, synchronizer flops=4'b1111.
- Synchronizer: col_in passes through 2 flops; all logic uses the synchronized value cs.
- Prescaler:
  - Free-running SCAN_DIV_W-bit up-counter.
  - tick is high for one clk when the counter equals all-ones; the counter then wraps to 0.
  - All FSM actions below occur only on tick cycles, except the key_valid clear.
- Column decode: hit = any cs bit low. col = lowest-index low bit, so simultaneous columns resolve to the lowest index.
- SCAN:
  - No hit: rotate row_out left by one (1110 -> 1101 -> 1011 -> 0111 -> 1110).
  - Hit: capture row index and col, count=1, row_out frozen, go to DEBOUNCE.
- DEBOUNCE:
  - Same hit column on this tick: count+1.
  - count reaches DEBOUNCE_SCANS: load key_code, pulse key_valid, set key_down=1, count=0, go to HELD.
  - No hit, or a different column: count=0, rotate row_out, go to SCAN.
  - With DEBOUNCE_SCANS=1, the press is accepted on the capture tick; the FSM goes SCAN -> HELD directly.
- HELD:
  - row_out stays frozen.
  - Tick with no hit: count+1. Tick with hit: count=0.
  - count reaches DEBOUNCE_SCANS: key_down=0, count=0, rotate row_out, go to SCAN. key_code keeps its value.
- key_valid is high for exactly one clk, the tick cycle of acceptance. It is cleared the following cycle.
- Press latency from a stable press on the currently driven row: 2 clk synchronizer + DEBOUNCE_SCANS ticks, +1 cycle registered output.
- A second key pressed while in HELD is ignored. Release requires all columns of the frozen row to be high.
- A key on a non-driven row is invisible until its row is driven, giving worst-case 3 extra ticks.
- Reset asserted mid-debounce or mid-hold: immediate return to reset values, with no key_valid pulse.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter runs on ticks.
  - After REPEAT_DELAY ticks of continuous hold, key_valid pulses with an unchanged key_code.
  - Further pulses follow every REPEAT_RATE ticks.
  - The counter clears on entry to HELD and whenever a tick sees no hit.
- Undefined: exactly one key_valid per accepted press. The repeat counter and both repeat parameters have no effect.

Test Plan (SCAN_DIV_W=4, DEBOUNCE_SCANS=4, tick every 16 clk):
- Reset release, col_in=4'b1111 held: row_out steps 1110,1101,1011,0111,1110 on successive ticks; key_valid and key_down stay 0.
- Row 2 press, col_in=4'b1011 while row_out=1011, held 10 ticks: key_code=4'hA, one key_valid pulse on the 4th matching tick, key_down=1, row_out frozen at 1011.
- Bounce: col_in low for 2 ticks, then high for 1, then stable low: the first attempt is aborted with no pulse; a single key_valid follows 4 stable ticks later.
- Release: col_in returns to 4'b1111 after the press above; key_down falls after 4 ticks, scanning resumes from 0111, key_code holds 4'hA.
- Simultaneous columns, col_in=4'b1001 on row 0: key_code=4'h1 (lowest column wins); reset asserted in HELD returns all outputs to reset values asynchronously.
- KEY_REPEAT_EN with REPEAT_DELAY=8, REPEAT_RATE=2, key held 14 ticks after acceptance: pulses at acceptance and at ticks +8, +10, +12, +14. Without the macro: exactly one pulse.
